// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host sequencer.
// Holds the host address map, the STATUS/CMD bit positions, the
// sequencer state encoding and the decoded-region encoding used by the
// address decoder.
package tpu_pkg;

    // Host address map (byte addresses, 8-byte words)
    localparam logic [15:0] A_BASE    = 16'h0100;
    localparam logic [15:0] B_BASE    = 16'h0200;
    localparam logic [15:0] C_BASE    = 16'h0300;
    localparam logic [15:0] CMD_ADDR  = 16'h0400;
    localparam logic [15:0] STAT_ADDR = 16'h0408;

    // STATUS read bits
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    // CMD write bits
    localparam int CMD_START   = 0;
    localparam int CMD_ERR_CLR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        RG_NONE = 3'd0,
        RG_A    = 3'd1,
        RG_B    = 3'd2,
        RG_C    = 3'd3,
        RG_CMD  = 3'd4,
        RG_STAT = 3'd5
    } region_e;

endpackage

// File: rtl/tpu_addr_decode.sv
// Combinational host address decoder.
// Ports:
//   addr   - host byte address
//   region - which register window the address hits (RG_NONE if unmapped)
//   row    - row index inside the A/B (8-byte rows) or C (16-byte rows) window
//   hi     - for C accesses, 1 selects the upper 64-bit half of the row
// Only 8-byte aligned addresses decode; anything else is unmapped.
module tpu_addr_decode
    import tpu_pkg::*;
#(
    parameter int ADDRW = 16,
    parameter int DIM   = 8
) (
    input  logic [ADDRW-1:0]         addr,
    output region_e                  region,
    output logic [$clog2(DIM)-1:0]   row,
    output logic                     hi
);

    localparam int RW = $clog2(DIM);

    // Window bounds; the bases are aligned to their window size, so the row
    // index can be taken straight from the address bits.
    localparam logic [ADDRW-1:0] A_LO = ADDRW'(A_BASE);
    localparam logic [ADDRW-1:0] A_HI = ADDRW'(32'(A_BASE) + DIM * 8);
    localparam logic [ADDRW-1:0] B_LO = ADDRW'(B_BASE);
    localparam logic [ADDRW-1:0] B_HI = ADDRW'(32'(B_BASE) + DIM * 8);
    localparam logic [ADDRW-1:0] C_LO = ADDRW'(C_BASE);
    localparam logic [ADDRW-1:0] C_HI = ADDRW'(32'(C_BASE) + DIM * 16);

    always_comb begin
        region = RG_NONE;
        row    = '0;
        hi     = 1'b0;
        if (addr[2:0] == 3'b000) begin
            if (addr >= A_LO && addr < A_HI) begin
                region = RG_A;
                row    = addr[3 +: RW];
            end else if (addr >= B_LO && addr < B_HI) begin
                region = RG_B;
                row    = addr[3 +: RW];
            end else if (addr >= C_LO && addr < C_HI) begin
                region = RG_C;
                row    = addr[4 +: RW];
                hi     = addr[3];
            end else if (addr == ADDRW'(CMD_ADDR)) begin
                region = RG_CMD;
            end else if (addr == ADDRW'(STAT_ADDR)) begin
                region = RG_STAT;
            end
        end
    end

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Host-facing sequencer for the TPU matrix-multiply datapath.
// Ports:
//   clk, rst_n        - clock; synchronous reset, active HIGH despite the name
//   req, r_w, addr    - one-cycle host access strobe, 1 = write, byte address
//   dataIn, dataOut   - host write data; registered read data (1-cycle latency)
//   a_wr_en, b_wr_en  - row write strobes into memA / memB, row = ab_row
//   feed_en, sa_en    - operand shift and MAC enables, high for the whole pass
//   sa_wr_en, sa_crow - C row load strobe and C row select (0 when no C access)
//   cin_row           - {dataIn, held low half} for C row loads
//   cout_row          - C row contents for row sa_crow
//   busy              - compute pass in progress
//   state_dbg         - current sequencer state, for observation only
// Host handshake: req is a single-cycle strobe with no back-pressure; writes
// take effect on that cycle, read data appears on dataOut after the next edge
// and is held until the next accepted read.
module tpu_seq_ctrl
    import tpu_pkg::*;
#(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8,
    parameter int ADDRW   = 16,
    parameter int DATAW   = 64,
    parameter int CYCLES  = 3 * DIM - 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      r_w,
    input  logic [ADDRW-1:0]          addr,
    input  logic [DATAW-1:0]          dataIn,
    output logic [DATAW-1:0]          dataOut,
    output logic                      a_wr_en,
    output logic                      b_wr_en,
    output logic [$clog2(DIM)-1:0]    ab_row,
    output logic                      feed_en,
    output logic                      sa_en,
    output logic                      sa_wr_en,
    output logic [$clog2(DIM)-1:0]    sa_crow,
    output logic [DIM*BITS_C-1:0]     cin_row,
    input  logic [DIM*BITS_C-1:0]     cout_row,
    output logic                      busy,
    output logic [1:0]                state_dbg
);

    localparam int RW   = $clog2(DIM);
    localparam int CNTW = $clog2(CYCLES);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CYCLES - 1);

    state_e            state, state_nxt;
    logic [CNTW-1:0]   cnt;
    logic              err;
    logic [DATAW-1:0]  lo;

    region_e           region;
    logic [RW-1:0]     row;
    logic              hi;

    logic              wr, rd, mem_acc, blocked, start, err_clr, err_set;
    logic [DATAW-1:0]  stat_word;

    tpu_addr_decode #(.ADDRW(ADDRW), .DIM(DIM)) u_dec (
        .addr   (addr),
        .region (region),
        .row    (row),
        .hi     (hi)
    );

    assign busy      = (state == RUN);
    assign state_dbg = state;
    assign wr        = req & r_w;
    assign rd        = req & ~r_w;
    assign mem_acc   = (region == RG_A) || (region == RG_B) || (region == RG_C);
    // Operand/accumulator accesses collide with the running pass
    assign blocked   = req & mem_acc & busy;
    assign start     = wr & (region == RG_CMD) & dataIn[CMD_START];
    assign err_clr   = wr & (region == RG_CMD) & dataIn[CMD_ERR_CLR];
    assign err_set   = blocked | (start & busy);
    assign cin_row   = {dataIn, lo};
    assign ab_row    = row;

    always_comb begin
        stat_word          = '0;
        stat_word[ST_BUSY] = busy;
        stat_word[ST_DONE] = (state == DONE);
        stat_word[ST_ERR]  = err;
    end

    // Next state and pass enables
    always_comb begin
        state_nxt = state;
        feed_en   = 1'b0;
        sa_en     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                feed_en = 1'b1;
                sa_en   = 1'b1;
                if (cnt == CNT_LAST) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Host-side strobes, all gated off while a pass is running
    always_comb begin
        a_wr_en  = 1'b0;
        b_wr_en  = 1'b0;
        sa_wr_en = 1'b0;
        sa_crow  = '0;
        if (req && !busy) begin
            a_wr_en  = r_w && (region == RG_A);
            b_wr_en  = r_w && (region == RG_B);
            sa_wr_en = r_w && (region == RG_C) && hi;
            if (region == RG_C) sa_crow = row;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            err     <= 1'b0;
            lo      <= '0;
            dataOut <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (busy && cnt != CNT_LAST) ? cnt + 1'b1 : '0;
            // A set in the same cycle as a clear wins, so no error is lost
            err   <= (err & ~err_clr) | err_set;
            if (wr && !busy && region == RG_C && !hi) lo <= dataIn;
            if (rd && !blocked) begin
                case (region)
                    RG_C:    dataOut <= hi ? cout_row[DATAW +: DATAW] : cout_row[0 +: DATAW];
                    RG_STAT: dataOut <= stat_word;
                    default: dataOut <= '0;
                endcase
            end
        end
    end

endmodule

// File: doc/tpu_seq_ctrl.md
Name: tpu_seq_ctrl

Overview:
Host-facing sequencer for the TPU matrix-multiply datapath (memA, memB, systolic_array). Decodes the memory-mapped host bus into row writes for the A/B operand memories and the C accumulator array. On a START command it runs a fixed-length compute pass and exposes busy/done status. Holds one C low-half word so 128-bit C rows can be written and read over the 64-bit bus.

Parameters:
BITS_AB, 8, operand element width
BITS_C, 16, accumulator element width
DIM, 8, array dimension (rows/cols)
ADDRW, 16, host address width
DATAW, 64, host data width; DIM*BITS_AB == DATAW, DIM*BITS_C == 2*DATAW
CYCLES, 3*DIM-2, compute-pass length in clocks (22 at default)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-high (asserted = 1 resets, despite the suffix)
req  in  1  host access strobe, one cycle per access
r_w  in  1  0 = read, 1 = write
addr  in  ADDRW  host byte address
dataIn  in  DATAW  host write data
dataOut  out  DATAW  registered host read data
a_wr_en  out  1  write current dataIn row into memA
b_wr_en  out  1  write current dataIn row into memB
ab_row  out  $clog2(DIM)  target row for A/B writes
feed_en  out  1  memA/memB shift enable during compute
sa_en  out  1  systolic_array MAC enable
sa_wr_en  out  1  load cin_row into C row sa_crow
sa_crow  out  $clog2(DIM)  C row select for write or read
cin_row  out  DIM*BITS_C  {dataIn, held low half} for C writes
cout_row  in  DIM*BITS_C  systolic_array Cout for row sa_crow
busy  out  1  compute pass in progress

Behaviour:
- Address map (byte addresses, 8-byte words): A row r at 0x0100+8r; B row r at 0x0200+8r; C row r low half at 0x0300+16r, high half at 0x0308+16r; CMD at 0x0400 (write bit0=1 → START); STATUS at 0x0408 (read: bit0 busy, bit1 done, bit2 err). Unmapped read returns 0; unmapped write is ignored.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on a START write. busy is 1 from the next cycle.
  - RUN holds feed_en = sa_en = 1 for exactly CYCLES cycles. A cycle counter runs 0..CYCLES-1.
  - RUN → DONE after the last counted cycle. busy drops the cycle after the last enabled cycle.
  - DONE behaves as IDLE but reports done = 1. A new START clears done and enters RUN.
- A/B writes: a_wr_en/b_wr_en are combinational from req & r_w & decode. ab_row = addr[3+:$clog2(DIM)]. Valid only in IDLE/DONE.
- C write, low half: dataIn latched into the internal lo register; no sa_wr_en.
- C write, high half: sa_wr_en = 1 for one cycle (combinational), with cin_row = {dataIn, lo} and sa_crow = row.
- C read: sa_crow = addr row (combinational). dataOut gets the selected half of cout_row registered on the next edge (1-cycle read latency). dataOut holds its value until the next read.
- Any A/B/C access while busy: the write or read is suppressed (no enables; dataOut unchanged) and sticky err is set. START while busy is ignored and sets err. err clears only on reset or a write of CMD bit1 = 1.
- A simultaneous START and CMD err-clear in the same write is allowed; both take effect.
- sa_crow = 0 when no C access is in progress.
- Reset: state IDLE, counter 0, busy 0, done 0, err 0, lo 0, dataOut 0, and all enables 0. Reset during RUN aborts the pass immediately; the next cycle is IDLE with no enables.

Decomposition:
- Package tpu_pkg: address constants (A_BASE, B_BASE, C_BASE, CMD_ADDR, STAT_ADDR), status bit indices, and the FSM state enum (IDLE/RUN/DONE).
- Optional sub-module tpu_addr_decode: combinational region/row/half decode, shared with future bus bridges.

Test Plan:
1. Reset, then read STATUS → dataOut = 0x0 one cycle after the request; all enables 0.
2. Write A row 3 at 0x0118 with 0x0102030405060708 → a_wr_en = 1 and ab_row = 3 that cycle; b_wr_en = 0.
3. Write C row 2 lo = 0x1111, hi = 0x2222 (0x0320, 0x0328) → sa_wr_en pulses only on the hi write, with sa_crow = 2 and cin_row = {0x2222, 0x1111}.
4. Write 0x1 to CMD at cycle t → busy = 1 on t+1..t+22; feed_en and sa_en high for exactly 22 cycles; STATUS afterwards = 0x2.
5. A write at 0x0100 during RUN, plus a second START → no a_wr_en; pass length still 22; STATUS = 0x6; write 0x2 to CMD → STATUS = 0x2.
6. Assert rst_n = 1 at cycle 10 of RUN → next cycle busy = 0, sa_en = 0, STATUS = 0x0; a fresh START runs a full 22 cycles.
